// File: rtl/window_buffer_3x3_pkg.sv
// window_buffer_3x3_pkg: shared pixel/kernel constants and the 3x3 kernel index map
package window_buffer_3x3_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int KERNEL_SIZE    = 3;
    localparam int KERNEL_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KIDX_CENTRE    = 4;
    function automatic int kidx(input int r, input int c);
        return r * KERNEL_SIZE + c;
    endfunction
endpackage

// File: rtl/window_buffer_3x3_if.sv
// window_buffer_3x3_if: pixel stream in, packed 3x3 kernel stream out
interface window_buffer_3x3_if import window_buffer_3x3_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int OUTPUT_WIDTH = DATA_WIDTH * KERNEL_TAPS;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   pixel_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] kernel;
    logic                    out_last;
    modport slave (
        input  in_valid, pixel_in, out_ready,
        output in_ready, out_valid, kernel, out_last
    );
    modport master (
        output in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, kernel, out_last
    );
endinterface

// File: rtl/window_buffer_3x3_line_buffer.sv
// window_buffer_3x3_line_buffer: one image row of pixels, async read, sync write
module window_buffer_3x3_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    assign rd_data = mem_q[addr];
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wr_data;
    end
endmodule

// File: rtl/window_buffer_3x3.sv
// window_buffer_3x3: raster pixel stream to 3x3 windows, one window per in-frame centre
module window_buffer_3x3 import window_buffer_3x3_pkg::*; #(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input logic                clk,
    input logic                rst,
    window_buffer_3x3_if.slave bus
);
    localparam int COL_W        = $clog2(IMAGE_WIDTH);
    localparam int ROW_W        = $clog2(IMAGE_HEIGHT);
    localparam int OUTPUT_WIDTH = DATA_WIDTH * KERNEL_TAPS;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [DATA_WIDTH-1:0]   win_q [KERNEL_TAPS];
    logic [DATA_WIDTH-1:0]   win_d [KERNEL_TAPS];
    logic [OUTPUT_WIDTH-1:0] kernel_q, kernel_d, win_flat;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   lb0_rd, lb1_rd;
    logic                    accept, emit, col_end, row_end;

    // A held output stalls the whole pipe, including pixels that would not emit
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign col_end       = col_q == COL_LAST;
    assign row_end       = row_q == ROW_LAST;
    assign emit          = accept && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
    assign bus.out_valid = out_valid_q;
    assign bus.kernel    = kernel_q;
    assign bus.out_last  = out_last_q;

    // lb0 holds row-1, lb1 holds row-2; lb1 takes lb0's old value on the same write
    window_buffer_3x3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_lb0 (
        .clk(clk), .we(accept), .addr(col_q), .wr_data(bus.pixel_in), .rd_data(lb0_rd)
    );
    window_buffer_3x3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_lb1 (
        .clk(clk), .we(accept), .addr(col_q), .wr_data(lb0_rd), .rd_data(lb1_rd)
    );

    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            win_d[kidx(r, 0)] = accept ? win_q[kidx(r, 1)] : win_q[kidx(r, 0)];
            win_d[kidx(r, 1)] = accept ? win_q[kidx(r, 2)] : win_q[kidx(r, 1)];
        end
        win_d[kidx(0, 2)] = accept ? lb1_rd       : win_q[kidx(0, 2)];
        win_d[kidx(1, 2)] = accept ? lb0_rd       : win_q[kidx(1, 2)];
        win_d[kidx(2, 2)] = accept ? bus.pixel_in : win_q[kidx(2, 2)];
        for (int i = 0; i < KERNEL_TAPS; i++) win_flat[i*DATA_WIDTH +: DATA_WIDTH] = win_d[i];
        col_d       = accept ? (col_end ? '0 : col_q + 1'b1) : col_q;
        row_d       = accept && col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
        out_valid_d = emit || (out_valid_q && !bus.out_ready);
        kernel_d    = emit ? win_flat : kernel_q;
        out_last_d  = emit ? (row_end && col_end) : out_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '{default: '0};
            kernel_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            kernel_q    <= kernel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
